// File: rtl/cl_serial_pkg.sv
// cl_serial shared definitions: FSM state encoding and logic op codes.
// Ports: none (package).
package cl_serial_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_XOR = 2'b10;
   localparam logic [1:0] OP_NOT = 2'b11;

endpackage

// File: rtl/cl_serial_if.sv
// cl_serial request/result bundle.
// master: drives start/a/b/S, reads out/zero/busy/done; slave: the reverse.
interface cl_serial_if #(
   parameter int N = 4
);

   logic         start;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic [1:0]   S;
   logic [N-1:0] out;
   logic         zero;
   logic         busy;
   logic         done;

   modport master (
      output start, a, b, S,
      input  out, zero, busy, done
   );

   modport slave (
      input  start, a, b, S,
      output out, zero, busy, done
   );

endinterface

// File: rtl/cl_serial_cl.sv
// cl: one-bit logic cell, y = a op b for op in {AND, OR, XOR, NOT a}.
// Ports: a, b (bit operands), s (2-bit op select), y (result bit).
module cl
   import cl_serial_pkg::*;
(
   input  logic       a,
   input  logic       b,
   input  logic [1:0] s,
   output logic       y
);

   always_comb begin
      y = 1'b0;
      unique case (s)
         OP_AND: y = a & b;
         OP_OR:  y = a | b;
         OP_XOR: y = a ^ b;
         OP_NOT: y = ~a;
      endcase
   end

endmodule

// File: rtl/cl_serial.sv
// cl_serial: bit-serial logic processor feeding/collecting the cl cell LSB first.
// Ports: clk, reset (async, active high), bus (cl_serial_if slave).
module cl_serial
   import cl_serial_pkg::*;
#(
   parameter int N = 4
) (
   input  logic        clk,
   input  logic        reset,
   cl_serial_if.slave  bus
);

   localparam int CNT_W = $clog2(N);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [N-1:0]     a_q, a_d;
   logic [N-1:0]     b_q, b_d;
   logic [1:0]       s_q, s_d;
   logic [N-1:0]     work_q, work_d;
   logic [N-1:0]     out_q, out_d;
   logic             zero_q, zero_d;
   logic             cell_y;

   cl u_cl (
      .a (a_q[cnt_q]),
      .b (b_q[cnt_q]),
      .s (s_q),
      .y (cell_y)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         work_q  <= '0;
         out_q   <= '0;
         zero_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         work_q  <= work_d;
         out_q   <= out_d;
         zero_q  <= zero_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      work_d  = work_q;
      out_d   = out_q;
      zero_d  = zero_q;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            // DONE accepts like IDLE so back-to-back ops lose no cycle
            if (bus.start) begin
               a_d     = bus.a;
               b_d     = bus.b;
               s_d     = bus.S;
               cnt_d   = '0;
               work_d  = '0;
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            // new bit enters at MSB; after N shifts bit 0 sits at LSB
            work_d = {cell_y, work_q[N-1:1]};
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
               out_d   = work_d;
               zero_d  = (work_d == '0);
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.out  = out_q;
   assign bus.zero = zero_q;
   assign bus.busy = (state_q == ST_RUN);
   assign bus.done = (state_q == ST_DONE);

endmodule

// File: tb/tb_cl_serial.sv
// Directed testbench for cl_serial (N=4) with hand-computed results.
// Ports: none.
module tb_cl_serial;

   localparam int N = 4;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   cl_serial_if #(.N(N)) bus ();

   cl_serial #(.N(N)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_rst(input string tag);
      check({tag, "_out"}, 32'(bus.out), 32'h0);
      check({tag, "_zero"}, 32'(bus.zero), 32'h1);
      check({tag, "_busy"}, 32'(bus.busy), 32'h0);
      check({tag, "_done"}, 32'(bus.done), 32'h0);
   endtask

   task automatic do_op(
      input string       tag,
      input logic [3:0]  av,
      input logic [3:0]  bv,
      input logic [1:0]  sv,
      input logic [3:0]  eo,
      input logic        ez,
      input bit          meddle
   );
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = av;
      bus.b     = bv;
      bus.S     = sv;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      for (int e = 1; e <= N; e++) begin
         @(posedge clk);
         #1;
         if (meddle && e == 1) begin
            bus.start = 1'b1;
            bus.a     = 4'b1111;
            bus.b     = 4'b1111;
            bus.S     = 2'b01;
         end
         if (meddle && e == 2) bus.start = 1'b0;
         check($sformatf("%s_busy%0d", tag, e),
               32'(bus.busy), 32'(e < N));
         check($sformatf("%s_done%0d", tag, e),
               32'(bus.done), 32'(e == N));
      end
      check({tag, "_out"}, 32'(bus.out), 32'(eo));
      check({tag, "_zero"}, 32'(bus.zero), 32'(ez));
      @(posedge clk);
      #1;
      check({tag, "_done_clr"}, 32'(bus.done), 32'h0);
      check({tag, "_idle"}, 32'(bus.busy), 32'h0);
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.S     = '0;
      #1;
      check_rst("rst0");
      @(negedge clk);
      reset = 1'b0;

      do_op("and", 4'b1100, 4'b1010, 2'b00, 4'b1000, 1'b0, 1'b0);
      do_op("or",  4'b1100, 4'b1010, 2'b01, 4'b1110, 1'b0, 1'b0);
      do_op("xor", 4'b1100, 4'b1010, 2'b10, 4'b0110, 1'b0, 1'b0);
      do_op("not", 4'b1100, 4'b1010, 2'b11, 4'b0011, 1'b0, 1'b0);

      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check_rst("arst");
      @(negedge clk);
      reset = 1'b0;

      do_op("pre", 4'b1100, 4'b1010, 2'b01, 4'b1110, 1'b0, 1'b0);
      do_op("zf",  4'b0101, 4'b1010, 2'b00, 4'b0000, 1'b1, 1'b0);
      do_op("intf", 4'b1100, 4'b1010, 2'b00, 4'b1000, 1'b0, 1'b1);

      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 4'b1100;
      bus.b     = 4'b1010;
      bus.S     = 2'b10;
      @(posedge clk);
      #1;
      for (int j = 1; j <= 9; j++) begin
         @(posedge clk);
         #1;
         check($sformatf("b2b_busy%0d", j),
               32'(bus.busy), 32'(j != 4 && j != 9));
         check($sformatf("b2b_done%0d", j),
               32'(bus.done), 32'(j == 4 || j == 9));
         if (j == 4) begin
            check("b2b_out1", 32'(bus.out), 32'h6);
            bus.S = 2'b01;
         end
         if (j == 5) bus.start = 1'b0;
         if (j == 9) check("b2b_out2", 32'(bus.out), 32'he);
      end
      @(posedge clk);
      #1;
      check("b2b_end", 32'(bus.busy), 32'h0);

      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 4'b1100;
      bus.b     = 4'b1010;
      bus.S     = 2'b00;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check_rst("mrst");
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("mrst_idle", 32'(bus.busy), 32'h0);
      do_op("post", 4'b1100, 4'b1010, 2'b00, 4'b1000, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
